// File: rtl/result_streamer_pkg.sv
// Shared types and buffer sizing for the result streamer slice.
// The burst FSM states and the skid-buffer geometry live here so the top and the FIFO agree.
package result_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FLUSH
    } state_e;

    localparam int BUF_DEPTH     = 2;
    localparam int BUF_PTR_WIDTH = 1;

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry skid FIFO holding returned results plus their last-of-burst tag.
// Accepts a push and a pop in the same cycle, even when full.
module result_skid_fifo
    import result_streamer_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         pushData_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         popData_o,
    output logic [BUF_PTR_WIDTH:0]   occupancy_o,
    output logic                     empty_o,
    output logic                     full_o
);

    logic [WIDTH-1:0]         entry_q [BUF_DEPTH];
    logic [BUF_PTR_WIDTH-1:0] rdPtr_q;
    logic [BUF_PTR_WIDTH-1:0] wrPtr_q;
    logic [BUF_PTR_WIDTH:0]   count_q;
    logic                     doPush;
    logic                     doPop;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == (BUF_PTR_WIDTH+1)'(BUF_DEPTH));
    assign doPop       = pop_i && !empty_o;
    assign doPush      = push_i && (!full_o || doPop);
    assign popData_o   = entry_q[rdPtr_q];
    assign occupancy_o = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                entry_q[wrPtr_q] <= pushData_i;
                wrPtr_q          <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/result_streamer.sv
// Burst engine that walks mem3 from start_addr for count words and streams the
// low RESULT_WIDTH bits of each word out over a valid/ready interface.
module result_streamer
    import result_streamer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int MEM_SIZE     = 32,
    parameter int RESULT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic [ADDR_WIDTH:0]     count,
    output logic                    mem_read_en,
    output logic [ADDR_WIDTH-1:0]   mem_read_address,
    input  logic [DATA_WIDTH-1:0]   mem_data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RESULT_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    state_e                   state_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [ADDR_WIDTH:0]      remain_q;
    logic                     inflight_q;
    logic                     inflightLast_q;
    logic                     done_q;

    logic                     popBeat;
    logic                     issueRead;
    logic                     flushDone;
    logic [BUF_PTR_WIDTH+1:0] pendingCount;
    logic [BUF_PTR_WIDTH:0]   occupancy;
    logic                     bufEmpty;
    logic                     bufFull;
    logic [RESULT_WIDTH:0]    headEntry;
    logic                     unusedDataBits;

    // Upper data bits beyond the result width are intentionally dropped.
    assign unusedDataBits = ^mem_data_in;

    result_skid_fifo #(
        .WIDTH (RESULT_WIDTH + 1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .pushData_i  ({inflightLast_q, mem_data_in[RESULT_WIDTH-1:0]}),
        .pop_i       (popBeat),
        .popData_o   (headEntry),
        .occupancy_o (occupancy),
        .empty_o     (bufEmpty),
        .full_o      (bufFull)
    );

    assign out_valid = !bufEmpty;
    assign out_data  = headEntry[RESULT_WIDTH-1:0];
    assign out_last  = headEntry[RESULT_WIDTH];
    assign popBeat   = out_valid && out_ready;

    // Buffered plus in-flight results, net of this cycle's pop, must leave room for one more.
    assign pendingCount = {1'b0, occupancy}
                        + (BUF_PTR_WIDTH+2)'(inflight_q)
                        - (BUF_PTR_WIDTH+2)'(popBeat);
    assign issueRead    = (state_q == READ) && (pendingCount < (BUF_PTR_WIDTH+2)'(BUF_DEPTH));

    assign flushDone = !inflight_q
                    && ((occupancy == '0)
                        || ((occupancy == (BUF_PTR_WIDTH+1)'(1)) && popBeat));

    assign mem_read_en      = issueRead;
    assign mem_read_address = addr_q;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            remain_q       <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q         <= 1'b0;
            inflight_q     <= issueRead;
            inflightLast_q <= issueRead && (remain_q == (ADDR_WIDTH+1)'(1));
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q   <= start_addr;
                            remain_q <= count;
                            state_q  <= READ;
                        end
                    end
                end
                READ: begin
                    if (issueRead) begin
                        addr_q   <= addr_q + ADDR_WIDTH'(1);
                        remain_q <= remain_q - (ADDR_WIDTH+1)'(1);
                        if (remain_q == (ADDR_WIDTH+1)'(1)) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Leave as the final beat drains so done lands the cycle the buffer is empty.
                    if (flushDone) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: a mem3 model, a queue-based stream
// scoreboard checked every cycle, and directed plus randomized bursts.
module tb_result_streamer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  start_addr;
    logic [5:0]  count;
    logic        mem_read_en;
    logic [4:0]  mem_read_address;
    logic [31:0] mem_data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [32];
    logic [4:0]  expAddrQ [$];
    logic [16:0] expDataQ [$];
    logic [15:0] popLog [$];
    logic        lastLog [$];
    logic [4:0]  readLog [$];

    bit          burstLive = 0;
    int          readyMode = 0;
    int          patIdx = 0;
    bit          pattern [6] = '{1, 0, 0, 1, 0, 1};

    int          issued = 0;
    int          popped = 0;
    bit          prevStall = 0;
    logic [16:0] prevBeat = '0;

    result_streamer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .mem_read_en      (mem_read_en),
        .mem_read_address (mem_read_address),
        .mem_data_in      (mem_data_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .busy             (busy),
        .done             (done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // mem3 read port: registered, data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_read_en) mem_data_in <= mem[mem_read_address];
    end

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: out_ready = 1;
                1: begin
                    out_ready = pattern[patIdx];
                    patIdx = (patIdx + 1) % 6;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard: read issue rule, read addresses, delivered beats and stall stability.
    always @(negedge clk) begin
        bit pop;
        int outstanding;
        if (rst) begin
            issued = 0;
            popped = 0;
            prevStall = 0;
        end else begin
            pop = out_valid && out_ready;
            outstanding = issued - popped;
            if (burstLive && expAddrQ.size() > 0)
                checkOutput("read_issue", mem_read_en, (outstanding - int'(pop)) < 2);
            else if (mem_read_en)
                checkOutput("spurious_read", mem_read_en, 0);
            if (mem_read_en) begin
                issued++;
                readLog.push_back(mem_read_address);
                if (expAddrQ.size() > 0) checkOutput("read_addr", mem_read_address, expAddrQ.pop_front());
            end
            if (prevStall) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_beat", {out_last, out_data}, prevBeat);
            end
            if (pop) begin
                popped++;
                popLog.push_back(out_data);
                lastLog.push_back(out_last);
                if (expDataQ.size() == 0) checkOutput("spurious_beat", out_valid, 0);
                else checkOutput("beat", {out_last, out_data}, expDataQ.pop_front());
            end
            prevStall = out_valid && !out_ready;
            prevBeat = {out_last, out_data};
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_read_en"}, mem_read_en, 0);
        checkOutput({tag, "_read_addr"}, mem_read_address, 0);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_data"}, out_data, 0);
        checkOutput({tag, "_last"}, out_last, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    task automatic applyStimulus(input int sa, input int n, input int midStart,
                                 output int doneCyc, output int firstValidCyc);
        int cyc;
        bit seen;
        popLog.delete();
        lastLog.delete();
        readLog.delete();
        for (int i = 0; i < n; i++) begin
            int a;
            a = (sa + i) % 32;
            expAddrQ.push_back(a[4:0]);
            expDataQ.push_back({(i == n - 1), mem[a][15:0]});
        end
        @(negedge clk);
        start = 1;
        start_addr = sa[4:0];
        count = n[5:0];
        @(posedge clk);
        #1;
        start = 0;
        burstLive = 1;
        cyc = 0;
        seen = 0;
        firstValidCyc = -1;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (out_valid && firstValidCyc < 0) firstValidCyc = cyc;
            if (cyc == midStart) begin
                start = 1;
                start_addr = 5'd7;
                count = 6'd3;
            end else begin
                start = 0;
            end
            if (done) seen = 1;
        end
        start = 0;
        burstLive = 0;
        doneCyc = seen ? cyc : -1;
        checkOutput("done_seen", seen, 1);
        if (seen) checkOutput("busy_at_done", busy, 0);
        checkOutput("reads_left", expAddrQ.size(), 0);
        checkOutput("beats_left", expDataQ.size(), 0);
    endtask

    initial begin
        int dc;
        int fv;
        int n;
        int sa;
        rst = 1;
        start = 0;
        start_addr = '0;
        count = '0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom();
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 0;
        @(negedge clk);

        // Basic burst, ready high: 5,10,15,20 from cycle 3, done at cycle 7.
        mem[0] = 32'hABCD_0005;
        mem[1] = 32'h1234_000A;
        mem[2] = 32'h0000_000F;
        mem[3] = 32'hFFFF_0014;
        applyStimulus(0, 4, -1, dc, fv);
        checkOutput("basic_first_valid", fv, 3);
        checkOutput("basic_done_cycle", dc, 7);
        checkOutput("basic_beats", popLog.size(), 4);
        checkOutput("basic_d0", popLog[0], 16'd5);
        checkOutput("basic_d1", popLog[1], 16'd10);
        checkOutput("basic_d2", popLog[2], 16'd15);
        checkOutput("basic_d3", popLog[3], 16'd20);
        checkOutput("basic_last_early", {lastLog[0], lastLog[1], lastLog[2]}, 3'b000);
        checkOutput("basic_last_final", lastLog[3], 1);

        // Address wrap 30,31,0,1.
        mem[30] = 32'h0000_0064;
        mem[31] = 32'h0001_0065;
        mem[0]  = 32'h0002_0066;
        mem[1]  = 32'h0003_0067;
        applyStimulus(30, 4, -1, dc, fv);
        checkOutput("wrap_addr0", readLog[0], 5'd30);
        checkOutput("wrap_addr1", readLog[1], 5'd31);
        checkOutput("wrap_addr2", readLog[2], 5'd0);
        checkOutput("wrap_addr3", readLog[3], 5'd1);
        checkOutput("wrap_d0", popLog[0], 16'h0064);
        checkOutput("wrap_d3", popLog[3], 16'h0067);
        checkOutput("wrap_done_cycle", dc, 7);

        // Backpressure with ready pattern 1,0,0,1,0,1.
        readyMode = 1;
        applyStimulus(5, 6, -1, dc, fv);
        checkOutput("bp_beats", popLog.size(), 6);
        readyMode = 0;

        // Zero count: done in cycle 1, no reads.
        applyStimulus(3, 0, -1, dc, fv);
        checkOutput("zero_done_cycle", dc, 1);
        checkOutput("zero_reads", readLog.size(), 0);

        // Start pulsed mid-burst is ignored.
        applyStimulus(12, 8, 4, dc, fv);
        checkOutput("midstart_done_cycle", dc, 11);
        checkOutput("midstart_beats", popLog.size(), 8);

        // Full-memory burst.
        applyStimulus(17, 32, -1, dc, fv);
        checkOutput("full_done_cycle", dc, 35);

        // Reset during FLUSH with two entries buffered.
        readyMode = 3;
        @(posedge clk);
        expAddrQ.push_back(5'd10);
        expAddrQ.push_back(5'd11);
        expDataQ.push_back({1'b0, mem[10][15:0]});
        expDataQ.push_back({1'b1, mem[11][15:0]});
        @(negedge clk);
        start = 1;
        start_addr = 5'd10;
        count = 6'd2;
        @(posedge clk);
        #1;
        start = 0;
        burstLive = 1;
        repeat (5) @(negedge clk);
        checkOutput("rst_pre_busy", busy, 1);
        checkOutput("rst_pre_valid", out_valid, 1);
        checkOutput("rst_pre_data", out_data, mem[10][15:0]);
        #2;
        rst = 1;
        #1;
        checkResetOutputs("midrst");
        burstLive = 0;
        expAddrQ.delete();
        expDataQ.delete();
        readyMode = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        applyStimulus(20, 5, -1, dc, fv);
        checkOutput("post_rst_done_cycle", dc, 8);
        checkOutput("post_rst_first_addr", readLog[0], 5'd20);

        // Randomized bursts with random contents and consumer behaviour.
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom();
            n = int'($urandom_range(0, 32));
            sa = int'($urandom_range(0, 31));
            readyMode = int'($urandom_range(0, 2));
            @(posedge clk);
            applyStimulus(sa, n, -1, dc, fv);
            if (readyMode == 0) checkOutput("rand_done_cycle", dc, (n == 0) ? 1 : n + 3);
            checkOutput("rand_beats", popLog.size(), n);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/result_streamer.md
# result_streamer

Drains dot-product results from the mem3 result memory and presents them as a valid/ready stream. It is the read-side counterpart of the mem3 write path: mem_writer fills mem3, and result_streamer empties it. It replaces host-driven random reads with a burst engine that walks `count` consecutive addresses from `start_addr`. It sits between mem3's read port and the downstream consumer, such as a UART/AXI-Stream bridge, and tolerates arbitrary consumer backpressure.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: mem3 word width.
- `ADDR_WIDTH`, default 5: mem3 address width.
- `MEM_SIZE`, default 32: mem3 depth. Must equal 2^ADDR_WIDTH.
- `RESULT_WIDTH`, default 16: streamed result width. Must be ≤ DATA_WIDTH.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a burst. Ignored while `busy`.
- `start_addr` in ADDR_WIDTH: first mem3 address, sampled with `start`.
- `count` in ADDR_WIDTH+1: number of results, 0..MEM_SIZE, sampled with `start`.
- `mem_read_en` out 1: mem3 read strobe.
- `mem_read_address` out ADDR_WIDTH: mem3 read address.
- `mem_data_in` in DATA_WIDTH: mem3 data, valid 1 cycle after `mem_read_en`.
- `out_valid` out 1: stream data valid.
- `out_ready` in 1: consumer accepts on `out_valid && out_ready`.
- `out_data` out RESULT_WIDTH: equals `mem_data_in[RESULT_WIDTH-1:0]`.
- `out_last` out 1: high with the final result of a burst.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse when a burst completes.

## Operation

- **FSM states:** IDLE, READ, FLUSH.
  - IDLE → READ on `start && count != 0`. Latches the address pointer and remaining-issue counter.
  - IDLE stays in IDLE on `start && count == 0`. `done` pulses on the next cycle. No reads are issued.
  - READ → FLUSH after the last read issues.
  - FLUSH → IDLE when the buffer is empty and no read is in flight. `done` pulses on that transition.
- **Read issue:** `mem_read_en` is high in READ iff `occupancy + inflight - pop < 2`.
  - `pop` = `out_valid && out_ready` in the same cycle.
  - One read is issued per cycle when that condition holds.
- **Address:** the address increments after each issued read and wraps from MEM_SIZE-1 to 0.
- **Buffer:** a 2-entry FIFO. Returning data is always written into it, and it can never overflow. `out_valid` = FIFO not empty.
- **out_last:** high on the entry tagged as the burst's final read.
- **busy:** high in READ and FLUSH.
- **start while busy:** ignored. No effect on pointers or counters.
- **Reset:** asserting `rst` at any time, including mid-burst, immediately returns the FSM to IDLE and empties the buffer. All outputs go to 0: `mem_read_en`, `mem_read_address`, `out_valid`, `out_data`, `out_last`, `busy`, `done`. Any in-flight read data is discarded.

## Timing

- `start` is sampled at edge 0. `mem_read_en` and the address are driven in cycle 1. Data appears on `mem_data_in` in cycle 2. `out_valid` goes high in cycle 3.
- First-result latency: 3 cycles.
- With `out_ready` held high, throughput is 1 result per cycle. A burst of N completes with `done` N+3 cycles after `start`.
- While `out_ready` is low, `out_valid`, `out_data` and `out_last` hold stable.
- Read issue stalls within 1 cycle of the buffer filling. It resumes in the same cycle as the pop that frees space.
- A new `start` is accepted in the cycle `done` is high, because the FSM is already in IDLE.

## Structure

- **Package `result_streamer_pkg`:**
  - FSM state enum (IDLE, READ, FLUSH).
  - `BUF_DEPTH = 2`.
  - `BUF_PTR_WIDTH = 1`.
- **Sub-module `result_skid_fifo`:** the 2-entry FIFO, parameterised on width. Each entry carries RESULT_WIDTH+1 bits (data plus last tag). It provides occupancy, push, pop, empty and full.
- **Top level:** FSM, address/count registers, in-flight flag, issue logic.

## Test plan

- **Basic burst:**
  - Stimulus: mem3[0..3] = 5, 10, 15, 20; `start`, `start_addr=0`, `count=4`; `out_ready=1`.
  - Response: `out_data` = 5, 10, 15, 20 on consecutive cycles from cycle 3; `out_last` only with 20; `done` at cycle 7.
- **Address wrap:**
  - Stimulus: `start_addr=30`, `count=4`.
  - Response: reads at addresses 30, 31, 0, 1; data streamed in that order.
- **Backpressure:**
  - Stimulus: `count=6`; `out_ready` toggles 1,0,0,1,0,1…
  - Response: no data lost or duplicated; at most 2 results buffered; `out_data` stable while stalled; `mem_read_en` never high with the buffer full.
- **Zero count / start while busy:**
  - Stimulus: `count=0`, then `start` pulsed mid-burst.
  - Response: `done` at cycle 1 with no `mem_read_en`; the mid-burst `start` does not alter the sequence or count.
- **Reset mid-burst:**
  - Stimulus: `rst` asserted during FLUSH with 2 entries buffered.
  - Response: all outputs 0 immediately; after release, a new burst streams correctly from its own `start_addr`.
